wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning Wishbone byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles from entering REQ to ack/err (range 2..65535).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have command ports: cmd_valid_i in 1, cmd_ready_o out 1, cmd_we_i in 1, cmd_adr_i in ADDR_WIDTH, cmd_dat_i in 32, cmd_sel_i in 4.
REQ-006 SHALL have response ports: rsp_valid_o out 1, rsp_ready_i in 1, rsp_dat_o out 32, rsp_err_o out 1, rsp_tmo_o out 1.
REQ-007 SHALL have pipelined Wishbone master ports: wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out ADDR_WIDTH; wb_sel_o out 4; wb_dat_o out 32; wb_dat_i in 32; wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i in 1.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, RESP; one transaction in flight maximum.
REQ-009 SHALL assert cmd_ready_o exactly when state is IDLE; the handshake (cmd_valid_i & cmd_ready_o) latches we/adr/dat/sel and moves to REQ next cycle.
REQ-010 SHALL, in REQ, drive wb_cyc_o=1, wb_stb_o=1, and hold the latched we/adr/sel/dat stable.
REQ-011 SHALL leave REQ on the first cycle with wb_stall_i=0: to RESP if wb_ack_i/wb_err_i/wb_rty_i is also high that cycle, otherwise to WAIT.
REQ-012 SHALL, in WAIT, drive wb_cyc_o=1, wb_stb_o=0, and move to RESP on the first cycle with wb_ack_i|wb_err_i|wb_rty_i.
REQ-013 SHALL, on termination, capture rsp_dat_o=wb_dat_i for reads (0 for writes), rsp_err_o=wb_err_i|wb_rty_i (err takes precedence over a simultaneous ack), and rsp_tmo_o=0.
REQ-014 SHALL, in RESP, drive wb_cyc_o=0, rsp_valid_o=1, and hold the rsp outputs stable until rsp_ready_i=1, then return to IDLE next cycle.
REQ-015 SHALL ignore wb_ack_i/wb_err_i/wb_rty_i in IDLE and RESP (late or spurious terminations).
REQ-016 SHALL complete with minimum latency: command handshake at cycle N, stb at N+1, rsp_valid_o at N+2 for a zero-wait slave acking in the same cycle as stb; a slave with fixed 2-cycle ack latency and no stall gives rsp_valid_o at N+4.
REQ-017 SHALL drive wb_dat_o from the latched command at all times, and wb_stb_o=0 whenever wb_cyc_o=0.

Reset
REQ-018 SHALL, with rst_n_i low at a clock edge, enter IDLE and clear wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o, rsp_tmo_o, rsp_dat_o, wb_adr_o, wb_sel_o, wb_dat_o to 0; cmd_ready_o is 1 from the first cycle after reset release.
REQ-019 SHALL, on reset mid-transaction, drop wb_cyc_o at the next edge, discard the transaction, and produce no response.

Configuration
REQ-020 SHALL, with WB_CMD_MASTER_TIMEOUT_EN defined, run a 16-bit counter cleared on entering REQ and incremented each REQ/WAIT cycle; on reaching TIMEOUT without termination it SHALL drop cyc/stb, go to RESP with rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0.
REQ-021 SHALL give termination priority over the timeout when both occur in the same cycle.
REQ-022 SHALL, without WB_CMD_MASTER_TIMEOUT_EN, omit the counter, hold rsp_tmo_o constant 0, and wait indefinitely in REQ/WAIT.

Verification
REQ-023 SHALL cover a write to 0x0 of 0xDEADBEEF, sel=0xF, against a 2-cycle-ack register slave -> rsp_valid_o at N+4, rsp_err_o=0, followed by a read returning 0xDEADBEEF.
REQ-024 SHALL cover wb_stall_i held high for 3 cycles -> wb_stb_o high for 4 cycles, adr/dat stable throughout, one response.
REQ-025 SHALL cover wb_err_i and wb_ack_i asserted together -> rsp_err_o=1, rsp_tmo_o=0.
REQ-026 SHALL cover TIMEOUT=8 with a silent slave and the macro defined -> cyc drops 8 cycles after REQ entry, rsp_tmo_o=1; a late ack is then ignored.
REQ-027 SHALL cover rsp_ready_i held low for 5 cycles -> rsp outputs stable, cmd_ready_o=0, and a new command is accepted only after the response handshake.
REQ-028 SHALL cover rst_n_i asserted in WAIT -> wb_cyc_o=0 next cycle, no rsp_valid_o, and cmd_ready_o=1 after release.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Single-outstanding command-port to pipelined Wishbone master.
// Optional per-transaction timeout is enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]           cmd_dat_i,
  input  logic [3:0]            cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_tmo_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state;
  logic   term;
  logic   done;
  logic   expire;

  assign term = wb_ack_i | wb_err_i | wb_rty_i;
  // A termination in REQ only counts once the strobe is accepted (no stall).
  assign done = ((state == REQ) && !wb_stall_i && term) || ((state == WAIT) && term);

  // Supported TIMEOUT range is 2..65535 (16-bit counter).
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_out_of_range
  end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign expire = (tmo_cnt + 16'd1) == 16'(TIMEOUT);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmo_cnt   <= '0;
      rsp_tmo_o <= 1'b0;
    end else begin
      if (state == IDLE)
        tmo_cnt <= '0;
      else if (state == REQ || state == WAIT)
        tmo_cnt <= tmo_cnt + 16'd1;
      if (done)
        rsp_tmo_o <= 1'b0;
      else if ((state == REQ || state == WAIT) && expire)
        rsp_tmo_o <= 1'b1;
    end
  end
`else
  assign expire    = 1'b0;
  assign rsp_tmo_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            state       <= REQ;
            cmd_ready_o <= 1'b0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            wb_we_o     <= cmd_we_i;
            wb_adr_o    <= cmd_adr_i;
            wb_sel_o    <= cmd_sel_i;
            wb_dat_o    <= cmd_dat_i;
          end
        end
        REQ, WAIT: begin
          if (done) begin
            state       <= RESP;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= wb_we_o ? 32'd0 : wb_dat_i;
            rsp_err_o   <= wb_err_i | wb_rty_i;
          end else if (expire) begin
            state       <= RESP;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= 32'd0;
            rsp_err_o   <= 1'b1;
          end else if (state == REQ && !wb_stall_i) begin
            state    <= WAIT;
            wb_stb_o <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small register slave and a response scoreboard.
// Timeout scenario runs when WB_CMD_MASTER_TIMEOUT_EN is defined; otherwise an indefinite-wait scenario.
module tb_wb_cmd_master;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [31:0]   cmd_dat = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_tmo;
  logic [31:0]   rsp_dat;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_rty, wb_stall;
  logic [AW-1:0] wb_adr;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_dat_m, wb_dat_s;

  wb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_m), .wb_dat_i(wb_dat_s),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_stall_i(wb_stall)
  );

  // Register slave: fixed ack latency (0 = same cycle as accepted stb), optional stall.
  int   lat = 2, stall_n = 0;
  logic silent = 1'b0, ack_en = 1'b1, err_en = 1'b0, rty_en = 1'b0, late_ack = 1'b0;
  int   stall_cnt = 0, pcnt = 0;
  logic pend = 1'b0;
  logic accept, term;
  logic [31:0] mem [0:15];

  assign wb_stall = wb_cyc && wb_stb && (stall_cnt < stall_n);
  assign accept   = wb_cyc && wb_stb && !wb_stall;
  assign term     = !silent && wb_cyc && ((lat == 0) ? accept : (pend && pcnt == lat));
  assign wb_ack   = late_ack | (term & ack_en);
  assign wb_err   = term & err_en;
  assign wb_rty   = term & rty_en;
  assign wb_dat_s = mem[wb_adr[5:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end
    if (!wb_cyc) begin
      pend <= 1'b0; pcnt <= 0; stall_cnt <= 0;
    end else begin
      if (wb_stb && wb_stall) stall_cnt <= stall_cnt + 1;
      if (accept && lat != 0) begin pend <= 1'b1; pcnt <= 1; end
      else if (pend) pcnt <= pcnt + 1;
      if (term) pend <= 1'b0;
      if (term && ack_en && wb_we)
        for (int b = 0; b < 4; b++)
          if (wb_sel[b]) mem[wb_adr[5:2]][b*8 +: 8] <= wb_dat_m[b*8 +: 8];
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {logic [31:0] dat; logic err; logic tmo;} rsp_t;
  rsp_t sb[$];
  int total = 0, passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e, input logic t);
    rsp_t r;
    r.dat = d; r.err = e; r.tmo = t;
    sb.push_back(r);
  endtask

  task automatic pop_chk(input string tag);
    rsp_t r;
    chk({tag, " sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, " dat"}, rsp_dat, r.dat);
      chk({tag, " err"}, rsp_err, r.err);
      chk({tag, " tmo"}, rsp_tmo, r.tmo);
    end
  endtask

  // Issue one command; elat < 0 skips the latency check; hold = cycles rsp_ready stays low.
  task automatic do_cmd(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] edat, input logic eerr,
                        input int elat, input int hold, output int stbs);
    int n, t;
    logic stable;
    logic [31:0] hd;
    logic he;
    stbs = 0; stable = 1'b1;
    @(negedge clk);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    n = cyc_n;
    push_exp(edat, eerr, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 100) begin
      if (wb_stb) stbs++;
      if (wb_cyc && (wb_adr !== adr || wb_dat_m !== dat || wb_sel !== sel || wb_we !== we)) stable = 1'b0;
      if (!wb_cyc && wb_stb) stable = 1'b0;
      @(negedge clk); t++;
    end
    chk({tag, " rsp_seen"}, rsp_valid, 1'b1);
    chk({tag, " wb_stable"}, stable, 1'b1);
    if (elat >= 0) chk({tag, " latency"}, cyc_n - n, elat);
    pop_chk(tag);
    if (hold > 0) begin
      hd = rsp_dat; he = rsp_err; stable = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3C;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_dat !== hd || rsp_err !== he || cmd_ready || wb_cyc) stable = 1'b0;
      end
      chk({tag, " hold_stable"}, stable, 1'b1);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, " rsp_done"}, rsp_valid, 1'b0);
    chk({tag, " ready_again"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int s, t;
    logic ok;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t;
    logic ok;
    repeat (3) @(negedge clk);
    chk("rst cyc", wb_cyc, 1'b0);
    chk("rst stb", wb_stb, 1'b0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst outs", {rsp_err, rsp_tmo, wb_we, rsp_dat, wb_sel}, '0);
    chk("rst adr_dat", {wb_adr, wb_dat_m}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 1'b1);

    // 2-cycle-ack register slave: write then read back.
    lat = 2;
    do_cmd("wr_deadbeef", 1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 4, 0, s);
    do_cmd("rd_deadbeef", 1'b0, 32'h0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 4, 0, s);
    do_cmd("wr_sel3", 1'b1, 32'h0, 32'h11223344, 4'h3, 32'h0, 1'b0, 4, 0, s);
    do_cmd("rd_sel3", 1'b0, 32'h0, 32'h0, 4'hF, 32'hDEAD3344, 1'b0, 4, 0, s);

    // Zero-wait slave.
    lat = 0;
    do_cmd("wr_zw", 1'b1, 32'h8, 32'h000000A5, 4'hF, 32'h0, 1'b0, 2, 0, s);
    do_cmd("rd_zw", 1'b0, 32'h8, 32'h0, 4'hF, 32'h000000A5, 1'b0, 2, 0, s);

    // Stall for 3 cycles.
    lat = 2; stall_n = 3;
    do_cmd("stall3", 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 7, 0, s);
    chk("stall3 stb_cycles", s, 4);
    chk("stall3 sb_empty", sb.size(), 0);
    stall_n = 0;

    // Error and ack together, then retry alone.
    err_en = 1'b1;
    do_cmd("err_ack", 1'b0, 32'h0, 32'h0, 4'hF, 32'hDEAD3344, 1'b1, 4, 0, s);
    err_en = 1'b0; ack_en = 1'b0; rty_en = 1'b1;
    do_cmd("rty", 1'b0, 32'h14, 32'h0, 4'hF, 32'hCAFEF00D, 1'b1, 4, 0, s);
    ack_en = 1'b1; rty_en = 1'b0;

    // Response back-pressure.
    do_cmd("hold5", 1'b0, 32'h8, 32'h0, 4'hF, 32'h000000A5, 1'b0, 4, 5, s);

    // Spurious ack while idle.
    @(negedge clk); late_ack = 1'b1;
    @(negedge clk); late_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack no_rsp", {rsp_valid, wb_cyc, cmd_ready}, 3'b001);

`ifndef WB_CMD_MASTER_TIMEOUT_EN
    // Without timeout the master waits as long as the slave is silent.
    silent = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    push_exp(32'hDEAD3344, 1'b0, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!wb_cyc || rsp_valid) ok = 1'b0;
    end
    chk("long_wait cyc_held", ok, 1'b1);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    chk("long_wait rsp_valid", rsp_valid, 1'b1);
    pop_chk("long_wait");
    @(negedge clk);
    silent = 1'b0;
`endif

    // Reset while in WAIT.
    silent = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h4;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (!(wb_cyc && !wb_stb) && t < 20) begin @(negedge clk); t++; end
    chk("rst_wait reached_wait", {wb_cyc, wb_stb}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wait cyc_drop", wb_cyc, 1'b0);
    chk("rst_wait no_rsp", rsp_valid, 1'b0);
    rst_n = 1'b1;
    silent = 1'b0;
    @(negedge clk);
    chk("rst_wait cmd_ready", cmd_ready, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc) ok = 1'b0;
    end
    chk("rst_wait quiet", ok, 1'b1);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Silent slave: timeout after TMO cycles of cyc, then a late ack must be ignored.
    silent = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0;
    push_exp(32'h0, 1'b1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (wb_cyc && t < 50) begin @(negedge clk); t++; end
    chk("tmo cyc_cycles", t, TMO);
    chk("tmo rsp_valid", rsp_valid, 1'b1);
    pop_chk("tmo");
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    chk("tmo late_ack", {rsp_valid, rsp_err, rsp_tmo, rsp_dat, cmd_ready}, {3'b111, 32'h0, 1'b0});
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("tmo done", {rsp_valid, cmd_ready}, 2'b01);
    silent = 1'b0;
`endif

    chk("final sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
